regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 175 +++++++++++++++++
 tb/tb_regfile_scoreboard.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Register file with a per-register "writeback pending" scoreboard.
// Reads are combinational on two independent ports. Writes and busy
// updates take effect on one rising clock edge. Register 0 always reads
// as zero and is never busy.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a writeback in the current cycle is forwarded to a read
//   port that addresses the same register. That port then returns wb_data
//   with busy = 0 in the same cycle.
//   When undefined, read ports return only the array contents and the
//   registered busy bits.
//
// Parameters
//   XLEN   - data width of each register
//   NREGS  - register count (power of two, >= 2); ADDR_W = log2(NREGS)
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous, active-high reset
//   rs1_addr, rs2_addr   read addresses
//   rs1_data, rs2_data   read data (combinational)
//   rs1_busy, rs2_busy   addressed register has a writeback pending
//   issue_valid/issue_rd mark a destination register pending
//   wb_valid/wb_rd/wb_data  writeback port (writes data, clears pending)
//   flush                clears every pending mark
//   busy_count           registered popcount of the pending marks
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic [ADDR_W:0]   busy_count
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR  = {ADDR_W{1'b0}};
    localparam logic [XLEN-1:0]   ZERO_DATA  = {XLEN{1'b0}};
    localparam logic [NREGS-1:0]  ZERO_MASK  = {NREGS{1'b0}};
    localparam logic [ADDR_W:0]   ZERO_COUNT = {(ADDR_W+1){1'b0}};

    // Number of set bits in a busy vector; the result never exceeds NREGS-1
    // because bit 0 is held at zero.
    function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] vec);
        logic [ADDR_W:0] acc;
        acc = ZERO_COUNT;
        for (int i = 0; i < NREGS; i++) begin
            acc = acc + {{ADDR_W{1'b0}}, vec[i]};
        end
        return acc;
    endfunction

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [ADDR_W:0]  busy_count_r;

    logic             wb_hit_s;
    logic             issue_hit_s;
    logic [NREGS-1:0] set_mask_s;
    logic [NREGS-1:0] clr_mask_s;
    logic [NREGS-1:0] busy_next_s;

    // Writes and issues aimed at register 0 are architecturally discarded.
    assign wb_hit_s    = wb_valid && (wb_rd != ZERO_ADDR);
    assign issue_hit_s = issue_valid && (issue_rd != ZERO_ADDR) && !flush;

    // One-hot decode of the issue (set) and writeback (clear) targets.
    always_comb begin
        set_mask_s = ZERO_MASK;
        clr_mask_s = ZERO_MASK;
        if (issue_hit_s) begin
            set_mask_s[issue_rd] = 1'b1;
        end else begin
            set_mask_s = ZERO_MASK;
        end
        if (wb_hit_s) begin
            clr_mask_s[wb_rd] = 1'b1;
        end else begin
            clr_mask_s = ZERO_MASK;
        end
    end

    // Next busy vector: flush beats everything; otherwise the set is applied
    // after the clear, so a same-register issue+wb leaves the bit set.
    always_comb begin
        busy_next_s = busy_r;
        if (flush) begin
            busy_next_s = ZERO_MASK;
        end else begin
            busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
        end
        busy_next_s[0] = 1'b0;
    end

    // Register array storage; a writeback writes data even during flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
        end else if (wb_hit_s) begin
            regs_r[wb_rd] <= wb_data;
        end
    end

    // Busy vector and its popcount, updated together so busy_count has no lag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r       <= ZERO_MASK;
            busy_count_r <= ZERO_COUNT;
        end else begin
            busy_r       <= busy_next_s;
            busy_count_r <= popcount(busy_next_s);
        end
    end

    assign busy_count = busy_count_r;

    // Read port 1: zero during reset or for address 0, optionally forwarded.
    always_comb begin
        rs1_data = ZERO_DATA;
        rs1_busy = 1'b0;
        if (reset || (rs1_addr == ZERO_ADDR)) begin
            rs1_data = ZERO_DATA;
            rs1_busy = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wb_hit_s && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
            rs1_busy = 1'b0;
        end
`endif
        else begin
            rs1_data = regs_r[rs1_addr];
            rs1_busy = busy_r[rs1_addr];
        end
    end

    // Read port 2: identical to port 1 and fully independent of it.
    always_comb begin
        rs2_data = ZERO_DATA;
        rs2_busy = 1'b0;
        if (reset || (rs2_addr == ZERO_ADDR)) begin
            rs2_data = ZERO_DATA;
            rs2_busy = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wb_hit_s && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
            rs2_busy = 1'b0;
        end
`endif
        else begin
            rs2_data = regs_r[rs2_addr];
            rs2_busy = busy_r[rs2_addr];
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Directed test for regfile_scoreboard (XLEN=32, NREGS=32).
// Stimulus drives each cycle shortly after the rising edge and pushes the
// hand-computed expected outputs for that cycle into a queue. A monitor
// samples on the falling edge, pops one entry and compares it.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic [ADDR_W:0]   busy_count;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .busy_count  (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [XLEN-1:0]   d1;
        logic              b1;
        logic [XLEN-1:0]   d2;
        logic              b2;
        logic [ADDR_W:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    logic chk_valid;
    int   n_checks;
    int   n_pass;

    // Monitor: one comparison per cycle that has an expectation posted.
    always @(negedge clk) begin
        if (chk_valid) begin
            exp_t e;
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL no_expectation: monitor found an empty queue");
            end else begin
                e = exp_q.pop_front();
                if (rs1_data === e.d1 && rs1_busy === e.b1 &&
                    rs2_data === e.d2 && rs2_busy === e.b2 &&
                    busy_count === e.cnt) begin
                    n_pass = n_pass + 1;
                end else begin
                    $display("FAIL %s: got d1=%h b1=%b d2=%h b2=%b cnt=%0d, want d1=%h b1=%b d2=%h b2=%b cnt=%0d",
                             e.name, rs1_data, rs1_busy, rs2_data, rs2_busy, busy_count,
                             e.d1, e.b1, e.d2, e.b2, e.cnt);
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [ADDR_W-1:0] ird,
                         input logic wv, input logic [ADDR_W-1:0] wrd,
                         input logic [XLEN-1:0] wd, input logic fl,
                         input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        issue_valid = iv;
        issue_rd    = ird;
        wb_valid    = wv;
        wb_rd       = wrd;
        wb_data     = wd;
        flush       = fl;
        rs1_addr    = a1;
        rs2_addr    = a2;
    endtask

    task automatic expect_out(input string nm, input logic [XLEN-1:0] d1, input logic b1,
                              input logic [XLEN-1:0] d2, input logic b2,
                              input logic [ADDR_W:0] cnt);
        exp_t e;
        e.name = nm; e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2; e.cnt = cnt;
        exp_q.push_back(e);
        chk_valid = 1'b1;
    endtask

    task automatic idle(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, a1, a2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        chk_valid = 1'b0;
        reset     = 1'b1;
        idle(5'd0, 5'd0);
        tick();

        // During reset: inputs are ignored and reads are forced to zero.
        drive(1'b1, 5'd3, 1'b1, 5'd3, 32'hCAFE_F00D, 1'b0, 5'd3, 5'd3);
        expect_out("in_reset", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tick();
        reset = 1'b0;

        // Read every address pair after reset.
        for (int i = 0; i < NREGS; i++) begin
            idle(i[ADDR_W-1:0], 5'(NREGS - 1 - i));
            expect_out($sformatf("post_reset_%0d", i), 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
            tick();
        end

        // Issue rd=5, then writeback 0xDEADBEEF.
        drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
        expect_out("issue5_same", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tick();
        drive(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd5, 5'd0);
        expect_out("wb5_same", BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 1'b0 : 1'b1,
                   32'h0, 1'b0, 6'd1);
        tick();
        idle(5'd5, 5'd5);
        expect_out("wb5_after", 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 6'd0);
        tick();

        // Register 0: issue and writeback both discarded.
        drive(1'b1, 5'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd0);
        expect_out("r0_same", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tick();
        idle(5'd0, 5'd0);
        expect_out("r0_after", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tick();

        // rd=7 busy, then same-cycle issue+wb on 7: data written, stays busy.
        drive(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
        expect_out("issue7", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd7, 32'h0000_00A5, 1'b0, 5'd7, 5'd5);
        expect_out("iss_wb7_same", BYP ? 32'h0000_00A5 : 32'h0, BYP ? 1'b0 : 1'b1,
                   32'hDEAD_BEEF, 1'b0, 6'd1);
        tick();
        idle(5'd7, 5'd5);
        expect_out("iss_wb7_after", 32'h0000_00A5, 1'b1, 32'hDEAD_BEEF, 1'b0, 6'd1);
        tick();

        // Issue to busy rd=7 and wb to non-busy rd=5: busy unchanged, data written.
        drive(1'b1, 5'd7, 1'b1, 5'd5, 32'h0000_0011, 1'b0, 5'd5, 5'd7);
        expect_out("noop_busy_same", BYP ? 32'h0000_0011 : 32'hDEAD_BEEF, 1'b0,
                   32'h0000_00A5, 1'b1, 6'd1);
        tick();
        idle(5'd5, 5'd7);
        expect_out("noop_busy_after", 32'h0000_0011, 1'b0, 32'h0000_00A5, 1'b1, 6'd1);
        tick();

        // Issue 3,4,9 then flush with a same-cycle issue of 10 and wb of 4.
        drive(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        tick();
        idle(5'd3, 5'd9);
        expect_out("pre_flush", 32'h0, 1'b1, 32'h0, 1'b1, 6'd4);
        tick();
        drive(1'b1, 5'd10, 1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd10, 5'd4);
        expect_out("flush_same", 32'h0, 1'b0, BYP ? 32'h0000_0044 : 32'h0,
                   BYP ? 1'b0 : 1'b1, 6'd4);
        tick();
        idle(5'd10, 5'd4);
        expect_out("flush_after", 32'h0, 1'b0, 32'h0000_0044, 1'b0, 6'd0);
        tick();

        // Writeback rd=2 read on rs2 in the same cycle.
        drive(1'b0, 5'd0, 1'b1, 5'd2, 32'h0000_0055, 1'b0, 5'd7, 5'd2);
        expect_out("bypass_same", 32'h0000_00A5, 1'b0, BYP ? 32'h0000_0055 : 32'h0,
                   1'b0, 6'd0);
        tick();
        idle(5'd2, 5'd2);
        expect_out("bypass_after", 32'h0000_0055, 1'b0, 32'h0000_0055, 1'b0, 6'd0);
        tick();

        // Fill every nonzero register: busy_count reaches NREGS-1.
        for (int i = 1; i < NREGS; i++) begin
            drive(1'b1, i[ADDR_W-1:0], 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
            tick();
        end
        drive(1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd31, 5'd1);
        expect_out("full", 32'h0, 1'b1, 32'h0, 1'b1, 6'd31);
        tick();

        // Asynchronous reset mid-operation, asserted between clock edges.
        drive(1'b1, 5'd6, 1'b1, 5'd2, 32'h0000_0099, 1'b0, 5'd2, 5'd7);
        #2;
        reset = 1'b1;
        expect_out("async_reset", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tick();
        reset = 1'b0;
        idle(5'd2, 5'd7);
        expect_out("after_reset", 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
        tick();
        idle(5'd0, 5'd0);
        tick();

        n_checks = n_checks + 1;
        if (exp_q.size() == 0) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL queue_drain: got %0d leftover entries, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
